// File: rtl/max7219_pkg.sv
// Shared constants, FSM state type and frame packing for the MAX7219 scheduler.
package max7219_pkg;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned FRAME_W    = 16;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned INIT_LEN   = 5;

  // MAX7219 register map
  localparam logic [ADDR_W-1:0] REG_NOOP      = 4'h0;
  localparam logic [ADDR_W-1:0] REG_DIGIT0    = 4'h1;
  localparam logic [ADDR_W-1:0] REG_DIGIT1    = 4'h2;
  localparam logic [ADDR_W-1:0] REG_DIGIT2    = 4'h3;
  localparam logic [ADDR_W-1:0] REG_DIGIT3    = 4'h4;
  localparam logic [ADDR_W-1:0] REG_DIGIT4    = 4'h5;
  localparam logic [ADDR_W-1:0] REG_DIGIT5    = 4'h6;
  localparam logic [ADDR_W-1:0] REG_DIGIT6    = 4'h7;
  localparam logic [ADDR_W-1:0] REG_DIGIT7    = 4'h8;
  localparam logic [ADDR_W-1:0] REG_DECODE    = 4'h9;
  localparam logic [ADDR_W-1:0] REG_INTENSITY = 4'hA;
  localparam logic [ADDR_W-1:0] REG_SCANLIM   = 4'hB;
  localparam logic [ADDR_W-1:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [ADDR_W-1:0] REG_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } sched_state_e;

  // Serial frame as shifted out to the display
  typedef struct packed {
    logic [3:0]        pad;
    logic [ADDR_W-1:0] addr;
    logic [SEG_W-1:0]  data;
  } frame_t;

  // Build a display frame from register address and data
  function automatic frame_t pack_frame(input logic [ADDR_W-1:0] addr,
                                        input logic [SEG_W-1:0]  data);
    frame_t f;
    f.pad  = 4'h0;
    f.addr = addr;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/max7219_sched_if.sv
// Request/serializer bus between the display clients and the scheduler.
interface max7219_sched_if;
  import max7219_pkg::*;

  logic [NUM_DIGITS*SEG_W-1:0] dig_data;
  logic                        dig_load;
  logic                        cfg_valid;
  logic [ADDR_W-1:0]           cfg_addr;
  logic [SEG_W-1:0]            cfg_data;
  logic                        cfg_ready;
  logic [FRAME_W-1:0]          tx_frame;
  logic                        tx_start;
  logic                        tx_busy;

  // Environment side: requesters plus the serializer's busy flag
  modport master (
    output dig_data, dig_load, cfg_valid, cfg_addr, cfg_data, tx_busy,
    input  cfg_ready, tx_frame, tx_start
  );

  // Scheduler side
  modport slave (
    input  dig_data, dig_load, cfg_valid, cfg_addr, cfg_data, tx_busy,
    output cfg_ready, tx_frame, tx_start
  );

endinterface

// File: rtl/max7219_init_rom.sv
// Power-up register initialisation table for the MAX7219.
module max7219_init_rom
  import max7219_pkg::*;
#(
  parameter logic [3:0] INIT_INTENSITY = 4'h8,
  parameter logic [2:0] SCAN_LIMIT     = 3'd7
) (
  input  logic [2:0]         idx,
  output logic [FRAME_W-1:0] frame,
  output logic               last
);

  localparam logic [2:0] LAST_IDX = 3'(INIT_LEN - 1);

  // Index to init frame: test off, no decode, scan limit, intensity, run
  always_comb begin
    frame = pack_frame(REG_NOOP, 8'h00);
    case (idx)
      3'd0:    frame = pack_frame(REG_TEST,      8'h00);
      3'd1:    frame = pack_frame(REG_DECODE,    8'h00);
      3'd2:    frame = pack_frame(REG_SCANLIM,   {5'b0, SCAN_LIMIT});
      3'd3:    frame = pack_frame(REG_INTENSITY, {4'h0, INIT_INTENSITY});
      3'd4:    frame = pack_frame(REG_SHUTDOWN,  8'h01);
      default: frame = pack_frame(REG_NOOP,      8'h00);
    endcase
  end

  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/max7219_sched.sv
// Arbitrates init, config and changed-digit frames onto one MAX7219 serializer.
module max7219_sched
  import max7219_pkg::*;
#(
  parameter logic [3:0]  INIT_INTENSITY = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
  parameter int unsigned ACK_TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  max7219_sched_if.slave   bus,
  output logic             init_done,
  output logic             busy
);

  localparam int unsigned       CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam int unsigned       SHD_W    = NUM_DIGITS * SEG_W;

  sched_state_e            state, state_d;
  logic [2:0]              init_ptr;
  logic [SHD_W-1:0]        shadow;
  logic [NUM_DIGITS-1:0]   dirty;
  logic [NUM_DIGITS-1:0]   dig_set;
  logic [NUM_DIGITS-1:0]   dig_clr;
  logic [2:0]              dig_idx;
  logic                    cfg_pend;
  logic [ADDR_W-1:0]       cfg_addr_q;
  logic [SEG_W-1:0]        cfg_data_q;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [FRAME_W-1:0]      frame_d;
  logic [FRAME_W-1:0]      rom_frame;
  logic                    rom_last;
  logic                    frame_load;
  logic                    tx_start_d;
  logic                    cfg_take;
  logic                    init_adv;
  logic                    init_fin;

  max7219_init_rom #(
    .INIT_INTENSITY (INIT_INTENSITY),
    .SCAN_LIMIT     (SCAN_LIMIT)
  ) u_rom (
    .idx   (init_ptr),
    .frame (rom_frame),
    .last  (rom_last)
  );

  // Digits whose incoming pattern differs from the shadow copy
  always_comb begin
    dig_set = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig_set[i] = bus.dig_load && (bus.dig_data[i*SEG_W +: SEG_W] != shadow[i*SEG_W +: SEG_W]);
    end
  end

  // Lowest pending digit wins
  always_comb begin
    dig_idx = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (dirty[i]) dig_idx = 3'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Next-state and per-cycle control
  always_comb begin
    state_d    = state;
    tx_start_d = 1'b0;
    frame_load = 1'b0;
    frame_d    = bus.tx_frame;
    cfg_take   = 1'b0;
    dig_clr    = '0;
    cnt_d      = cnt;
    init_adv   = 1'b0;
    init_fin   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!init_done) begin
          frame_load = 1'b1;
          frame_d    = rom_frame;
          state_d    = ST_ISSUE;
          tx_start_d = 1'b1;
        end else if (cfg_pend) begin
          frame_load = 1'b1;
          frame_d    = pack_frame(cfg_addr_q, cfg_data_q);
          cfg_take   = 1'b1;
          state_d    = ST_ISSUE;
          tx_start_d = 1'b1;
        end else if (|dirty) begin
          frame_load = 1'b1;
          frame_d    = pack_frame(REG_DIGIT0 + {1'b0, dig_idx},
                                  shadow[{dig_idx, 3'b000} +: SEG_W]);
          dig_clr    = NUM_DIGITS'(1) << dig_idx;
          state_d    = ST_ISSUE;
          tx_start_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          // serializer never picked the frame up; reissue it unchanged
          state_d    = ST_ISSUE;
          tx_start_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ST_IDLE;
          if (!init_done) begin
            init_adv = 1'b1;
            init_fin = rom_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: frame, timeout, config slot, init pointer, shadow/dirty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.tx_start <= 1'b0;
      bus.tx_frame <= '0;
      cnt          <= '0;
      cfg_pend     <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      init_ptr     <= '0;
      init_done    <= 1'b0;
      dirty        <= '0;
      shadow       <= '0;
    end else begin
      bus.tx_start <= tx_start_d;
      if (frame_load) bus.tx_frame <= frame_d;
      cnt <= cnt_d;
      if (bus.cfg_valid && !cfg_pend) begin
        cfg_pend   <= 1'b1;
        cfg_addr_q <= bus.cfg_addr;
        cfg_data_q <= bus.cfg_data;
      end else if (cfg_take) begin
        cfg_pend <= 1'b0;
      end
      if (init_adv && !rom_last) init_ptr <= init_ptr + 3'd1;
      // a reload in the selection cycle re-marks the digit after the clear
      if (init_fin) begin
        init_done <= 1'b1;
        dirty     <= '1;
      end else begin
        dirty <= (dirty & ~dig_clr) | dig_set;
      end
      if (bus.dig_load) shadow <= bus.dig_data;
    end
  end

  assign bus.cfg_ready = ~cfg_pend;
  assign busy = (state != ST_IDLE) || !init_done || cfg_pend || (|dirty);

endmodule
